// File: rtl/symbol_tile_reader.sv
// Scans a 16x16 tile of the 160x120 framebuffer and reports per-row hit masks
// and a total hit count for pixels matching MATCH_COLOUR.
module symbol_tile_reader #(
  parameter logic [2:0] MATCH_COLOUR = 3'b011
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [7:0]  i_x,
  input  logic [6:0]  i_y,
  output logic [7:0]  o_rd_x,
  output logic [6:0]  o_rd_y,
  output logic        o_rd_en,
  input  logic [2:0]  i_rd_colour,
  output logic [15:0] o_row_mask,
  output logic [3:0]  o_row_idx,
  output logic        o_row_valid,
  output logic [8:0]  o_count,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  typedef struct packed {
    logic       inr;
    logic [3:0] col;
    logic [3:0] row;
  } slot_t;

  state_t      r_state, w_next;
  logic [7:0]  r_xl;
  logic [6:0]  r_yl;
  logic [7:0]  r_k;
  logic        r_drain;
  logic [1:0]  r_vld_pipe;
  slot_t       r_s, r_e;
  logic [15:0] r_mask;

  logic        w_accept, w_issue, w_inr, w_hit, w_row_end;
  logic [7:0]  w_slot, w_bx;
  logic [6:0]  w_by;
  logic [8:0]  w_cx;
  logic [7:0]  w_ry;
  logic [15:0] w_mask_full;

  assign w_accept = (r_state == IDLE) && i_start;
  assign w_issue  = w_accept || ((r_state == SCAN) && (r_k != 8'hFF));
  assign o_busy   = (r_state != IDLE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = SCAN;
      SCAN:    if (r_k == 8'hFF) w_next = DRAIN;
      DRAIN:   if (r_drain) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Next slot's address; on accept the raw inputs feed slot 0 directly so the
  // first read lands in cycle 1.
  assign w_bx   = w_accept ? i_x : r_xl;
  assign w_by   = w_accept ? i_y : r_yl;
  assign w_slot = w_accept ? 8'd0 : r_k + 8'd1;
  assign w_cx   = {1'b0, w_bx} + {5'd0, w_slot[3:0]};
  assign w_ry   = {1'b0, w_by} + {4'd0, w_slot[7:4]};
  assign w_inr  = (w_cx < 9'd160) && (w_ry < 8'd120);

  assign w_hit     = r_vld_pipe[1] && r_e.inr && (i_rd_colour == MATCH_COLOUR);
  assign w_row_end = r_vld_pipe[1] && (r_e.col == 4'hF);

  always_comb begin
    w_mask_full = r_mask;
    w_mask_full[r_e.col] = w_hit;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_xl        <= '0;
      r_yl        <= '0;
      r_k         <= '0;
      r_drain     <= 1'b0;
      r_vld_pipe  <= '0;
      r_s         <= '0;
      r_e         <= '0;
      r_mask      <= '0;
      o_rd_x      <= '0;
      o_rd_y      <= '0;
      o_rd_en     <= 1'b0;
      o_row_mask  <= '0;
      o_row_idx   <= '0;
      o_row_valid <= 1'b0;
      o_count     <= '0;
      o_done      <= 1'b0;
    end else begin
      r_drain    <= (r_state == DRAIN) && !r_drain;
      r_vld_pipe <= {r_vld_pipe[0], w_issue};
      r_e        <= r_s;

      if (w_accept) begin
        r_xl <= i_x;
        r_yl <= i_y;
        r_k  <= '0;
      end else if (w_issue) begin
        r_k <= r_k + 8'd1;
      end

      // Read stage: address and in-range flag registered together.
      if (w_issue) begin
        o_rd_x  <= w_cx[7:0];
        o_rd_y  <= w_ry[6:0];
        o_rd_en <= w_inr;
        r_s     <= '{inr: w_inr, col: w_slot[3:0], row: w_slot[7:4]};
      end else begin
        o_rd_en <= 1'b0;
      end

      // Evaluate stage: one cycle behind the read stage.
      if (w_accept) begin
        r_mask  <= '0;
        o_count <= '0;
      end else if (r_vld_pipe[1]) begin
        r_mask <= w_row_end ? 16'h0000 : w_mask_full;
        if (w_hit) o_count <= o_count + 9'd1;
      end

      o_row_valid <= w_row_end;
      o_done      <= w_row_end && (r_e.row == 4'hF);
      if (w_accept) begin
        o_row_mask <= '0;
        o_row_idx  <= '0;
      end else if (w_row_end) begin
        o_row_mask <= w_mask_full;
        o_row_idx  <= r_e.row;
      end
    end
  end

endmodule

// File: tb/tb_symbol_tile_reader.sv
// Bench for symbol_tile_reader: table of tile scans checked cycle by cycle,
// with row results matched against a scoreboard queue, plus reset sequences.
module tb_symbol_tile_reader;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_x = '0;
  logic [6:0]  i_y = '0;
  logic [2:0]  i_rd_colour = '0;
  logic [7:0]  o_rd_x;
  logic [6:0]  o_rd_y;
  logic        o_rd_en;
  logic [15:0] o_row_mask;
  logic [3:0]  o_row_idx;
  logic        o_row_valid;
  logic [8:0]  o_count;
  logic        o_busy;
  logic        o_done;

  symbol_tile_reader dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start),
    .i_x(i_x), .i_y(i_y),
    .o_rd_x(o_rd_x), .o_rd_y(o_rd_y), .o_rd_en(o_rd_en),
    .i_rd_colour(i_rd_colour),
    .o_row_mask(o_row_mask), .o_row_idx(o_row_idx), .o_row_valid(o_row_valid),
    .o_count(o_count), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int x;
    int y;
    int mode;       // 0: all 011, 1: only (13,27)=011, 2: only (13,27)=111
    int exp_count;
  } vec_t;

  typedef struct {
    int          row;
    logic [15:0] mask;
  } row_t;

  vec_t vecs[7];
  row_t sbq[$];
  int   nerr = 0;
  int   nchk = 0;
  int   mem_mode = 0;
  logic [2:0] pending = '0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] pix(input int mode, input int px, input int py);
    if (mode == 0) return 3'b011;
    if (px == 13 && py == 27) return (mode == 1) ? 3'b011 : 3'b111;
    return 3'b000;
  endfunction

  // Framebuffer with 1-cycle latency; non-requested cycles return the match
  // colour so clipped slots are proven to be ignored.
  task automatic mem_step();
    i_rd_colour = pending;
    pending = o_rd_en ? pix(mem_mode, int'(o_rd_x), int'(o_rd_y)) : 3'b011;
  endtask

  task automatic push_rows(input vec_t v);
    row_t r;
    for (int rr = 0; rr < 16; rr++) begin
      r.row  = rr;
      r.mask = '0;
      for (int c = 0; c < 16; c++)
        if ((v.x + c) < 160 && (v.y + rr) < 120 && pix(v.mode, v.x + c, v.y + rr) == 3'b011)
          r.mask[c] = 1'b1;
      sbq.push_back(r);
    end
  endtask

  task automatic drive_start(input vec_t v);
    i_x = v.x[7:0];
    i_y = v.y[6:0];
    i_start = 1'b1;
    mem_mode = v.mode;
    push_rows(v);
  endtask

  // Runs one scan from the start edge through cycle 259; chain >= 0 issues the
  // next table entry's start in cycle 259.
  task automatic scan(input int idx, input bit pre, input int busy_at, input int chain);
    vec_t v;
    int k, cx, ry;
    bit en, due;
    row_t r;
    v = vecs[idx];
    if (!pre) begin
      @(negedge i_clk);
      mem_step();
      drive_start(v);
    end
    @(posedge i_clk);
    for (int cyc = 1; cyc <= 259; cyc++) begin
      @(negedge i_clk);
      mem_step();
      i_start = 1'b0;
      if (cyc == busy_at) begin
        i_start = 1'b1; i_x = '0; i_y = '0;
      end
      chk("busy", int'(o_busy), (cyc <= 258) ? 1 : 0);
      if (cyc <= 256) begin
        k  = cyc - 1;
        cx = v.x + (k % 16);
        ry = v.y + (k / 16);
        en = (cx < 160) && (ry < 120);
        chk("rd_en", int'(o_rd_en), int'(en));
        if (en) begin
          chk("rd_x", int'(o_rd_x), cx);
          chk("rd_y", int'(o_rd_y), ry);
        end
      end else begin
        chk("rd_en_drain", int'(o_rd_en), 0);
      end
      due = (cyc >= 18) && (cyc <= 258) && ((cyc - 18) % 16 == 0);
      if (o_row_valid || due) chk("row_valid", int'(o_row_valid), int'(due));
      if (o_row_valid && due) begin
        if (sbq.size() == 0) chk("row_queue", sbq.size(), 1);
        else begin
          r = sbq.pop_front();
          chk("row_idx", int'(o_row_idx), r.row);
          chk("row_mask", int'(o_row_mask), int'(r.mask));
          chk("row_cycle", cyc, 16 * r.row + 18);
        end
      end
      if (o_done || cyc == 258) chk("done", int'(o_done), (cyc == 258) ? 1 : 0);
      if (cyc == 2)   chk("count_cleared", int'(o_count), 0);
      if (cyc == 258) chk("count_final", int'(o_count), v.exp_count);
      if (cyc == 259) chk("count_hold", int'(o_count), v.exp_count);
      if (cyc == 259 && chain >= 0) drive_start(vecs[chain]);
    end
    if (chain < 0) chk("rows_left", sbq.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_x"}, int'(o_rd_x), 0);
    chk({tag, "_rd_y"}, int'(o_rd_y), 0);
    chk({tag, "_rd_en"}, int'(o_rd_en), 0);
    chk({tag, "_row_mask"}, int'(o_row_mask), 0);
    chk({tag, "_row_idx"}, int'(o_row_idx), 0);
    chk({tag, "_row_valid"}, int'(o_row_valid), 0);
    chk({tag, "_count"}, int'(o_count), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_done"}, int'(o_done), 0);
  endtask

  initial begin
    vecs[0] = '{x: 10,  y: 20,  mode: 0, exp_count: 256};
    vecs[1] = '{x: 10,  y: 20,  mode: 1, exp_count: 1};
    vecs[2] = '{x: 10,  y: 20,  mode: 2, exp_count: 0};
    vecs[3] = '{x: 150, y: 112, mode: 0, exp_count: 80};
    vecs[4] = '{x: 10,  y: 20,  mode: 1, exp_count: 1};
    vecs[5] = '{x: 150, y: 112, mode: 0, exp_count: 80};
    vecs[6] = '{x: 144, y: 104, mode: 0, exp_count: 256};

    // Power-up reset
    repeat (3) @(negedge i_clk);
    chk_all_zero("por");
    i_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      chk("idle_busy", int'(o_busy), 0);
    end

    for (int i = 0; i < 4; i++) scan(i, 1'b0, -1, -1);
    scan(4, 1'b0, 50, 5);
    scan(5, 1'b1, -1, -1);
    scan(6, 1'b0, -1, -1);

    // Reset mid-scan: asserted mid-cycle in cycle 100, takes effect before any edge
    @(negedge i_clk);
    mem_step();
    i_x = 8'd10; i_y = 7'd20; i_start = 1'b1; mem_mode = 0;
    @(posedge i_clk);
    for (int cyc = 1; cyc < 100; cyc++) begin
      @(negedge i_clk);
      mem_step();
      i_start = 1'b0;
    end
    @(posedge i_clk);
    #2 i_reset_n = 1'b0;
    #1 chk_all_zero("async_rst");
    for (int i = 0; i < 5; i++) @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      mem_step();
      chk("post_rst_busy", int'(o_busy), 0);
      chk("post_rst_row_valid", int'(o_row_valid), 0);
      chk("post_rst_done", int'(o_done), 0);
    end
    scan(1, 1'b0, -1, -1);
    scan(0, 1'b0, -1, -1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/symbol_tile_reader.md
# symbol_tile_reader

Scans a 16x16 pixel tile of the 160x120, 3-bit-colour framebuffer and reports which pixels hold a target colour. It is the read-back counterpart of the symbol drawing blocks. Those blocks write a symbol's pixels at base (x, y) plus a 4-bit offset; this block reads the same tile back and returns per-row 16-bit hit masks and a total hit count. Game logic uses the results for symbol detection and collision checks. It sits between the control FSM and the framebuffer read port, which has a 1-cycle read latency.

## Interface
- MATCH_COLOUR, 3'b011: colour counted as a hit.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a scan; sampled only in IDLE.
- x  in  8  tile base column; latched on accepted start.
- y  in  7  tile base row; latched on accepted start.
- rd_x  out  8  framebuffer read column.
- rd_y  out  7  framebuffer read row.
- rd_en  out  1  read request; data is returned on rd_colour one cycle later.
- rd_colour  in  3  framebuffer read data.
- row_mask  out  16  hit mask of the last completed row; bit c is column offset c (bit 0 is leftmost).
- row_idx  out  4  row offset of row_mask.
- row_valid  out  1  1-cycle pulse when row_mask and row_idx are new.
- count  out  9  running hit total, 0..256.
- busy  out  1  scan in progress.
- done  out  1  1-cycle pulse when the scan is complete.

## Operation
- States: IDLE, SCAN, DRAIN.
  - IDLE: start=1 latches x and y, clears count and the mask shift register, and moves to SCAN.
  - SCAN: 256 slots, k = 0..255, with col = k[3:0] and row = k[7:4].
    - Each slot drives rd_x = x_l + col and rd_y = y_l + row.
    - SCAN moves to DRAIN after k = 255.
  - DRAIN: 2 cycles to collect the last data, then return to IDLE.
- Clipping:
  - The column sum is computed in 9 bits and the row sum in 8 bits.
  - A slot is out of range if the column sum is 160 or more, or the row sum is 120 or more.
  - For an out-of-range slot: rd_en=0, and rd_x/rd_y carry the truncated low bits.
  - The returned data for that slot is treated as a miss regardless of rd_colour.
- Hit evaluation, in the cycle after slot k:
  - hit = the delayed in-range flag AND (rd_colour == MATCH_COLOUR).
  - The hit bit is written into bit col of the mask register.
  - count increments by 1 on each hit.
- Row completion:
  - When the col=15 data of a row has been evaluated, the next cycle presents the full mask on row_mask.
  - In that same cycle row_idx = row and row_valid = 1.
  - The mask register clears for the next row.
- start while busy: ignored, no restart, and x/y are not re-latched.
- Reset values, asserted asynchronously: state IDLE; rd_x, rd_y, rd_en, row_mask, row_idx, row_valid, count, busy, done are all 0.
- Reset mid-scan: abort immediately, with no row_valid or done. A start after reset release begins a fresh scan.
- count and row_mask hold their values after done until the next accepted start.

## Timing
- Let cycle 0 be the cycle in which start=1 is sampled in IDLE.
- busy=1 from cycle 1 through cycle 258.
- Slot k drives rd_en/rd_x/rd_y in cycle k+1 (cycles 1..256).
- rd_colour for slot k is evaluated in cycle k+2.
- row_valid for row r is high in cycle 16r+18, i.e. cycles 18, 34, …, 258.
- Row 15: row_valid, done=1 and the final count are all presented in cycle 258.
- busy=0 from cycle 259, and the block is in IDLE.
- The earliest next start is sampled in cycle 259.
- Total latency from start to done: 258 cycles.
- rd_en is registered with rd_x/rd_y, so there is no combinational path from rd_colour to the read outputs.

## Test plan
- Reset: assert reset_n=0 mid-cycle.
  - All outputs go to 0 without waiting for a clock edge.
  - After release, busy stays 0 until start.
- Full tile: memory model returns 3'b011 everywhere, x=10, y=20.
  - rd_en is high in cycles 1..256, with the first read at (10,20) and the last at (25,35).
  - 16 row_valid pulses, each with row_mask=16'hFFFF.
  - done in cycle 258 with count=256.
- Single pixel: only (13,27) is 3'b011 and everything else is 3'b000, with x=10, y=20.
  - Row 7 has mask 16'h0008; all other rows have mask 0.
  - Final count=1.
  - Repeating with rd_colour=3'b111 at that pixel gives count=0.
- Clipping: x=150, y=112, all pixels 3'b011.
  - rd_en is never asserted for col 10..15 or row 8..15.
  - Rows 0..7 have mask 16'h03FF; rows 8..15 have mask 16'h0000.
  - Final count=80.
- Busy start: pulse start with x=0, y=0 in cycle 50 of a scan at x=10, y=20.
  - Addresses stay based at (10,20) and done is still in cycle 258.
  - A start in cycle 259 is accepted.
- Reset mid-scan: assert reset_n=0 in cycle 100.
  - No row_valid or done follows.
  - A new start after release produces a complete, correct 258-cycle scan with count starting from 0.
